// File: rtl/start_screen_pkg.sv
// Shared types and constants for the start-screen renderer and its ROM image.
package start_screen_pkg;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOW     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  localparam int LEVEL_MAX  = 8;
  localparam int LEVEL_W    = 4;
  localparam int ROM_AW     = 17;
  localparam int IMG_WIDTH  = 384;
  localparam int IMG_HEIGHT = 192;
  localparam int IMG_WORDS  = IMG_WIDTH * IMG_HEIGHT;

  // Scale one 8-bit channel by level/8 (level 8 = unity, level 0 = black).
  function automatic logic [7:0] fade_channel(input logic [7:0] ch,
                                              input logic [LEVEL_W-1:0] level);
    logic [11:0] prod;
    prod = 12'(ch) * 12'(level);
    return prod[10:3];
  endfunction

endpackage

// File: rtl/start_screen_renderer_fade_scaler.sv
// One colour channel of the output stage: brightness scale plus blanking.
module fade_scaler
  import start_screen_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               en,
  input  logic [7:0]         ch,
  input  logic [LEVEL_W-1:0] level,
  output logic [7:0]         px
);

  logic [7:0] px_d;
  logic [7:0] px_q;

  // Blanked pixels are forced black, visible ones are scaled by the fade level.
  always_comb begin
    px_d = 8'd0;
    if (en) px_d = fade_channel(ch, level);
  end

  // Output register of the last pipeline stage.
  always_ff @(posedge Clk) begin
    if (Reset) px_q <= 8'd0;
    else       px_q <= px_d;
  end

  assign px = px_q;

endmodule

// File: rtl/start_screen_renderer.sv
// Start-screen renderer: address generation for the palette ROM, fade sequencing
// and brightness scaling of the decoded colour. DrawX/DrawY to RGB is 3 cycles.
module start_screen_renderer
  import start_screen_pkg::*;
#(
  parameter int          X0          = 128,
  parameter int          Y0          = 144,
  parameter int          IMG_W       = IMG_WIDTH,
  parameter int          IMG_H       = IMG_HEIGHT,
  parameter int          FADE_FRAMES = 4,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              display_en,
  input  logic              vs,
  input  logic              show_req,
  input  logic              start_press,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              active,
  output logic              screen_done
);

  // Pipeline registers
  logic [ROM_AW-1:0] rom_addr_d, rom_addr_q;
  logic              in_img_s1_d, in_img_s1_q, in_img_s2_q;
  logic              en_s1_d, en_s1_q, en_s2_q;
  logic [9:0]        dx, dy;

  // Sequencer registers
  state_t             state_d, state_q;
  logic [LEVEL_W-1:0] level_d, level_q;
  logic [3:0]         frame_cnt_d, frame_cnt_q;
  logic               vs_q;
  logic               done_d, done_q;
  logic               active_d, active_q;
  logic               tick, step;

  // S1: region test via wrapping 10-bit offsets, so pixels left of/above the image fail too.
  always_comb begin
    dx          = DrawX - 10'(X0);
    dy          = DrawY - 10'(Y0);
    in_img_s1_d = (dx < 10'(IMG_W)) && (dy < 10'(IMG_H));
    en_s1_d     = display_en;
    rom_addr_d  = '0;
    if (in_img_s1_d) rom_addr_d = ROM_AW'(dy) * ROM_AW'(IMG_W) + ROM_AW'(dx);
  end

  // S1/S2 registers: address to the ROM plus flags delayed to match its latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_q  <= '0;
      in_img_s1_q <= 1'b0;
      en_s1_q     <= 1'b0;
      in_img_s2_q <= 1'b0;
      en_s2_q     <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      in_img_s1_q <= in_img_s1_d;
      en_s1_q     <= en_s1_d;
      in_img_s2_q <= in_img_s1_q;
      en_s2_q     <= en_s1_q;
    end
  end

  // S3: one scaler per channel, red in the top byte.
  logic [23:0] src;
  logic [7:0]  px_out [3];

  assign src = in_img_s2_q ? rom_data : BG_COLOR;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      fade_scaler u_scaler (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (en_s2_q),
        .ch    (src[23-8*gi -: 8]),
        .level (level_q),
        .px    (px_out[gi])
      );
    end
  endgenerate

  assign Red   = px_out[0];
  assign Green = px_out[1];
  assign Blue  = px_out[2];

  // Frame tick on the vs falling edge; a fade step every FADE_FRAMES ticks.
  assign tick = vs_q & ~vs;
  assign step = tick && (frame_cnt_q == 4'(FADE_FRAMES - 1));

  // Next-state logic; start_press beats a coincident step while fading in.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    if (tick) frame_cnt_d = step ? 4'd0 : frame_cnt_q + 4'd1;
    case (state_q)
      HIDDEN: begin
        level_d = '0;
        if (show_req) state_d = FADE_IN;
      end
      FADE_IN: begin
        if (start_press) begin
          state_d = FADE_OUT;
        end else if (step) begin
          level_d = level_q + 1'b1;
          if (level_q == LEVEL_W'(LEVEL_MAX - 1)) state_d = SHOW;
        end
      end
      SHOW: begin
        level_d = LEVEL_W'(LEVEL_MAX);
        if (start_press) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        // A fade-out started at level 0 still finishes on its next step.
        if (step) begin
          if (level_q <= LEVEL_W'(1)) begin
            level_d = '0;
            state_d = HIDDEN;
            done_d  = 1'b1;
          end else begin
            level_d = level_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = HIDDEN;
        level_d = '0;
      end
    endcase
    if (state_d != state_q) frame_cnt_d = 4'd0;
    active_d = (state_d != HIDDEN);
  end

  // Sequencer state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= HIDDEN;
      level_q     <= '0;
      frame_cnt_q <= 4'd0;
      vs_q        <= 1'b0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      vs_q        <= vs;
      done_q      <= done_d;
      active_q    <= active_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign active      = active_q;
  assign screen_done = done_q;

endmodule

// File: doc/start_screen_renderer.md
Name: start_screen_renderer

Overview:
- Pixel-pipeline stage directly upstream of the start-screen palette ROM.
- Converts the VGA controller's DrawX/DrawY into a 17-bit ROM address for a 384x192 indexed image placed at (X0,Y0).
- Consumes the ROM's decoded 24-bit colour, applies a frame-stepped fade-in/fade-out brightness, and drives the RGB outputs, with the blanking/region flags aligned to the ROM latency.
- Sequences the title screen: HIDDEN -> FADE_IN -> SHOW -> FADE_OUT, with a one-cycle done pulse back to the game FSM.

Parameters:
- X0, 128, left edge of image in screen pixels
- Y0, 144, top edge of image in screen pixels
- IMG_W, 384, image width in pixels
- IMG_H, 192, image height in pixels (IMG_W*IMG_H = 73728 ROM words)
- FADE_FRAMES, 4, frames per one fade-level step (1..15)
- BG_COLOR, 24'h000000, colour outside the image rectangle

Ports:
- Clk  in  1  system/pixel clock
- Reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column from VGA controller
- DrawY  in  10  current pixel row
- display_en  in  1  1 = visible pixel (not blanking)
- vs  in  1  VGA vertical sync, active-low
- show_req  in  1  1-cycle pulse: begin displaying start screen
- start_press  in  1  1-cycle pulse: player pressed start
- rom_addr  out  17  read address to palette ROM
- rom_data  in  24  decoded colour from ROM (valid 1 cycle after rom_addr is registered)
- Red, Green, Blue  out  8 each  final pixel colour
- active  out  1  1 whenever state != HIDDEN
- screen_done  out  1  1-cycle pulse when FADE_OUT reaches level 0

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs at any time, including mid-fade):
  - state = HIDDEN, level = 0, frame counter = 0
  - rom_addr = 0; Red/Green/Blue = 0; active = 0; screen_done = 0
  - all pipeline valid/region flags cleared
- Pipeline (3 cycles DrawX/DrawY -> RGB):
  - S1: in_img = (DrawX-X0) < IMG_W and (DrawY-Y0) < IMG_H, using unsigned 10-bit subtraction so wrap-around rejects pixels left of or above the image.
  - S1: rom_addr <= in_img ? (DrawY-Y0)*IMG_W + (DrawX-X0) : 0. The product is 17-bit; max 73727, no overflow.
  - S1: register in_img and display_en.
  - S2: ROM registers its data; S1 flags are delayed one more stage.
  - S3: select src = in_img ? rom_data : BG_COLOR. Each channel <= (ch * level) >> 3, with an 8x4 multiply to 12 bits, keeping bits [10:3]. Level 8 passes the channel unchanged; level 0 gives 0.
  - S3: if the delayed display_en = 0, output 0.
  - Level used is the value sampled at S3, so it changes only on frame boundaries.
- Frame tick: registered vs; tick = falling edge of vs (1 cycle). frame_cnt counts ticks 0..FADE_FRAMES-1. step = tick and frame_cnt == FADE_FRAMES-1. frame_cnt clears on every state entry.
- FSM (level range 0..8):
  - HIDDEN: level 0. show_req -> FADE_IN.
  - FADE_IN: on step, level++; when level becomes 8 -> SHOW. start_press -> FADE_OUT from the current level, without waiting.
  - SHOW: level 8. start_press -> FADE_OUT. show_req ignored.
  - FADE_OUT: on step, level--; when level becomes 0 -> HIDDEN with screen_done = 1 for exactly one cycle. show_req and start_press ignored.
- Simultaneous events:
  - start_press wins over step in FADE_IN; level is not incremented that cycle.
  - show_req in any state other than HIDDEN is ignored.
- active = (state != HIDDEN), registered.

Decomposition:
- Shared package start_screen_pkg:
  - state enum (HIDDEN, FADE_IN, SHOW, FADE_OUT)
  - LEVEL_MAX = 8, LEVEL_W = 4
  - ROM_AW = 17, image dimension constants shared with the ROM image generator
- One sub-module: fade_scaler (one channel multiply/shift; instantiate 3x).
- Address and region logic stay inline.

Test Plan:
- Reset held 2 cycles mid-FADE_OUT -> next cycle: state HIDDEN, RGB = 0, active = 0, no screen_done pulse.
- SHOW state:
  - DrawX=128, DrawY=144 -> rom_addr = 0.
  - DrawX=511, DrawY=335 -> rom_addr = 73727.
  - rom_data = 24'hb28558 -> RGB = b2/85/58 exactly 3 cycles after DrawX/DrawY.
- SHOW, DrawX=127 or DrawX=512 or DrawY=143 -> rom_addr = 0 and RGB = BG_COLOR; DrawX=0 with X0=128 must not wrap into the image.
- show_req, FADE_FRAMES=4 -> level steps 0,1,..,8 every 4 vs falling edges; enters SHOW after 32 ticks. At level 4, rom_data 24'hffffff -> RGB = 7f/7f/7f.
- start_press in FADE_IN at level 3 coinciding with a step -> FADE_OUT at level 3, reaches 0 after 12 ticks. screen_done is high for 1 cycle, then active = 0.
- display_en = 0 inside the image in SHOW -> RGB = 0 with correct 3-cycle alignment; vs held low for many cycles -> only one tick counted.
